led_band_gs_writer: RTL and testbench

- Streams one full grayscale frame (N_WORDS × 48-bit words) into a TLC5957 LED driver chain on SOUT/SCLK/LAT.
- Sits downstream of the FC configuration stage and shares the driver line with it. It takes the line only after FC setup has completed and the `en` handoff is granted.
- Fetches words from the pixel buffer through a request/valid handshake.
- Generates SCLK internally from clk and issues the WRTGS and LATGS latch commands.

---
 rtl/led_band_gs_writer.sv | 151 +++++++++++++++
 tb/tb_led_band_gs_writer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_band_gs_writer.sv
// led_band_gs_writer: streams one grayscale frame of N_WORDS x WORD_W-bit
// words into a TLC5957 chain over SOUT/SCLK/LAT. Words are fetched from the
// pixel buffer with a rd_req/rd_valid handshake, SCLK is divided down from
// clk, and LAT carries WRTGS (1 bit) on every word but the last, which
// carries LATGS (3 bits).
// Optional build macro GS_LINE_RESET_EN: the final word carries LINERESET
// (7 LAT bits) instead of LATGS.
module led_band_gs_writer #(
  parameter int CLK_DIV = 5,
  parameter int WORD_W  = 48,
  parameter int N_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  output logic              rd_req,
  input  logic [WORD_W-1:0] rd_data,
  input  logic              rd_valid,
  output logic              SCLK,
  output logic              SOUT,
  output logic              LAT,
  output logic              busy,
  output logic              done
);

  localparam int BIT_W  = $clog2(WORD_W + 1);
  localparam int WCNT_W = $clog2(N_WORDS + 1);
  localparam int DIV_W  = $clog2(CLK_DIV + 1);
`ifdef GS_LINE_RESET_EN
  localparam int LAST_L = 7;
`else
  localparam int LAST_L = 3;
`endif

  // First bit index at which LAT goes high, for ordinary and final words
  localparam logic [BIT_W-1:0]  WRT_START  = BIT_W'(WORD_W - 1);
  localparam logic [BIT_W-1:0]  LAST_START = BIT_W'(WORD_W - LAST_L);
  localparam logic [BIT_W-1:0]  LAST_BIT   = BIT_W'(WORD_W - 1);
  localparam logic [WCNT_W-1:0] LAST_WORD  = WCNT_W'(N_WORDS - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WORD_W-1:0]  shreg;
  logic [BIT_W-1:0]   bit_cnt;
  logic [WCNT_W-1:0]  word_cnt;
  logic [DIV_W-1:0]   div_cnt;

  logic               phase_end;
  logic               fall_evt;
  logic               word_end;
  logic               last_word;
  logic [BIT_W-1:0]   lat_start;
  logic [BIT_W-1:0]   bit_nxt;

  assign phase_end = (state == SHIFT) && (div_cnt == DIV_LAST);
  assign fall_evt  = phase_end && SCLK;
  assign word_end  = fall_evt && (bit_cnt == LAST_BIT);
  assign last_word = (word_cnt == LAST_WORD);
  assign lat_start = last_word ? LAST_START : WRT_START;
  assign bit_nxt   = bit_cnt + BIT_W'(1);
  assign rd_req    = (state == FETCH);

  // State register; reset abandons any frame in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: start only when idle and granted, words until the last
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && en) state_nxt = FETCH;
      FETCH:   if (rd_valid) state_nxt = SHIFT;
      SHIFT:   if (word_end) state_nxt = last_word ? DONE : FETCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: word capture, SCLK divider, bit shifting and LAT framing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      div_cnt  <= '0;
      SCLK     <= 1'b0;
      SOUT     <= 1'b0;
      LAT      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && en) begin
            busy     <= 1'b1;
            word_cnt <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
          end
        end
        FETCH: begin
          if (rd_valid) begin
            shreg   <= rd_data;
            SOUT    <= rd_data[WORD_W-1];
            LAT     <= (lat_start == '0);
            bit_cnt <= '0;
            div_cnt <= '0;
            SCLK    <= 1'b0;
          end
        end
        SHIFT: begin
          if (phase_end) begin
            div_cnt <= '0;
            SCLK    <= ~SCLK;
            if (fall_evt) begin
              shreg <= {shreg[WORD_W-2:0], 1'b0};
              if (word_end) begin
                SOUT     <= 1'b0;
                LAT      <= 1'b0;
                bit_cnt  <= '0;
                word_cnt <= word_cnt + WCNT_W'(1);
                if (last_word) begin
                  done <= 1'b1;
                  busy <= 1'b0;
                end
              end else begin
                bit_cnt <= bit_nxt;
                SOUT    <= shreg[WORD_W-2];
                LAT     <= (bit_nxt >= lat_start);
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_led_band_gs_writer.sv
// Testbench for led_band_gs_writer: a cycle-level behavioural model derived
// from frame timing arithmetic, a TLC5957-style receiver that captures SIN on
// SCLK rising edges and latches on LAT falling edges, and a randomized pixel
// buffer responder. Honours GS_LINE_RESET_EN for the final-word LAT width.
module tb_led_band_gs_writer;

  localparam int CLK_DIV    = 5;
  localparam int WORD_W     = 48;
  localparam int N_WORDS    = 16;
  localparam int SHIFT_CLKS = WORD_W * 2 * CLK_DIV;
`ifdef GS_LINE_RESET_EN
  localparam int LAST_L = 7;
`else
  localparam int LAST_L = 3;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              en = 1'b1;
  logic              start = 1'b0;
  logic              rd_req;
  logic [WORD_W-1:0] rd_data = '0;
  logic              rd_valid = 1'b0;
  logic              SCLK, SOUT, LAT, busy, done;

  led_band_gs_writer #(.CLK_DIV(CLK_DIV), .WORD_W(WORD_W), .N_WORDS(N_WORDS)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .rd_req(rd_req),
    .rd_data(rd_data), .rd_valid(rd_valid), .SCLK(SCLK), .SOUT(SOUT),
    .LAT(LAT), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cycle = 0;

  function automatic int lat_len(input int w);
    return (w == N_WORDS - 1) ? LAST_L : 1;
  endfunction

  task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Behavioural model: frame progress in words and clocks-into-word
  bit                m_busy = 0, m_fetch = 0, m_done = 0;
  int                m_word = 0, m_k = 0;
  logic [WORD_W-1:0] m_cur = '0;
  logic [WORD_W-1:0] exp_words[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_fetch = 0; m_done = 0; m_word = 0; m_k = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_busy) begin
      if (start && en) begin
        m_busy = 1; m_fetch = 1; m_word = 0;
      end
    end else if (m_fetch) begin
      if (rd_valid) begin
        m_cur = rd_data;
        exp_words.push_back(rd_data);
        m_fetch = 0;
        m_k = 0;
      end
    end else begin
      m_k++;
      if (m_k == SHIFT_CLKS) begin
        m_word++;
        if (m_word == N_WORDS) begin
          m_busy = 0; m_done = 1;
        end else begin
          m_fetch = 1;
        end
      end
    end
  end

  // Every-cycle compare of all outputs against the model
  always @(negedge clk) begin
    logic e_sclk, e_sout, e_lat;
    int b;
    cycle++;
    e_sclk = 0; e_sout = 0; e_lat = 0;
    if (m_busy && !m_fetch) begin
      b      = m_k / (2 * CLK_DIV);
      e_sclk = (m_k % (2 * CLK_DIV)) >= CLK_DIV;
      e_sout = m_cur[WORD_W-1-b];
      e_lat  = b >= (WORD_W - lat_len(m_word));
    end
    n_vec++;
    if ({busy, done, rd_req, SCLK, SOUT, LAT} !==
        {m_busy, m_done, m_busy && m_fetch, e_sclk, e_sout, e_lat}) begin
      n_err++;
      $display("[TB] FAIL cycle_outputs @%0d: got busy/done/req/sclk/sout/lat=%b expected %b",
               cycle, {busy, done, rd_req, SCLK, SOUT, LAT},
               {m_busy, m_done, m_busy && m_fetch, e_sclk, e_sout, e_lat});
    end
  end

  // Driver receiver: shift on SCLK rise, latch on LAT fall
  int                sclk_rises = 0;
  int                lat_hi = 0;
  int                done_cnt = 0;
  logic [WORD_W-1:0] drv_sh = '0;
  logic [WORD_W-1:0] latch_q[$];
  int                latw_q[$];

  always @(posedge SCLK) begin
    drv_sh = {drv_sh[WORD_W-2:0], SOUT};
    sclk_rises++;
    if (LAT) lat_hi++;
  end

  always @(negedge LAT) begin
    latch_q.push_back(drv_sh);
    latw_q.push_back(lat_hi);
    lat_hi = 0;
  end

  always @(negedge clk) if (done) done_cnt++;

  // Pixel buffer responder with configurable latency, stalls and noise
  bit pattern_mode = 1, rand_delay = 0, noise_en = 0, offered = 0;
  int base_delay = 1, stall_word = -1, serve_idx = 0, stall = 0, cur_delay = 1;

  always @(posedge clk) begin
    #2;
    if (!rd_req) begin
      stall   = 0;
      offered = 0;
      rd_valid = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      rd_data  = WORD_W'({$urandom(), $urandom()});
      cur_delay = (serve_idx == stall_word) ? 20 :
                  base_delay + (rand_delay ? int'($urandom_range(0, 3)) : 0);
    end else if (!offered) begin
      if (stall >= cur_delay) begin
        offered  = 1;
        rd_valid = 1'b1;
        rd_data  = pattern_mode ? WORD_W'(48'h000100020003 + 48'(serve_idx))
                                : WORD_W'({$urandom(), $urandom()});
        serve_idx++;
      end else begin
        stall++;
        rd_valid = 1'b0;
      end
    end
  end

  task automatic clear_frame_state();
    latch_q.delete(); latw_q.delete(); exp_words.delete();
    sclk_rises = 0; done_cnt = 0; lat_hi = 0; serve_idx = 0;
  endtask

  task automatic apply_stimulus();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, input bit chaos);
    bit seen;
    seen = 0;
    for (int n = 0; n < max_cycles && !seen; n++) begin
      @(posedge clk); #2;
      if (chaos) begin
        en    = 1'($urandom_range(0, 1));
        start = ($urandom_range(0, 63) == 0);
      end
      @(negedge clk);
      if (done) seen = 1;
    end
    start = 1'b0;
    en    = 1'b1;
    if (!seen) check_output("done_timeout", 64'(0), 64'(1));
    repeat (3) @(negedge clk);
  endtask

  task automatic check_frame(input bit pattern);
    check_output("sclk_rises", 64'(sclk_rises), 64'(N_WORDS * WORD_W));
    check_output("done_pulses", 64'(done_cnt), 64'(1));
    check_output("latch_count", 64'(latch_q.size()), 64'(N_WORDS));
    check_output("served_count", 64'(exp_words.size()), 64'(N_WORDS));
    if (latch_q.size() == N_WORDS && exp_words.size() == N_WORDS) begin
      for (int i = 0; i < N_WORDS; i++) begin
        check_output($sformatf("gs_word%0d", i), 64'(latch_q[i]), 64'(exp_words[i]));
        check_output($sformatf("lat_width%0d", i), 64'(latw_q[i]), 64'(lat_len(i)));
      end
      if (pattern) begin
        check_output("gs_word0_lit", 64'(latch_q[0]), 64'h000100020003);
        check_output("gs_word7_lit", 64'(latch_q[7]), 64'h00010002000a);
        check_output("gs_word15_lit", 64'(latch_q[15]), 64'h000100020012);
      end
`ifdef GS_LINE_RESET_EN
      check_output("last_lat_lit", 64'(latw_q[N_WORDS-1]), 64'(7));
`else
      check_output("last_lat_lit", 64'(latw_q[N_WORDS-1]), 64'(3));
`endif
    end
  endtask

  initial begin
    bit found;
    int rises_before;

    // Reset held with start asserted: nothing may move
    rst = 1'b0; start = 1'b1; en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_output("reset_outputs", 64'({SCLK, SOUT, LAT, rd_req, busy, done}), 64'(0));
    end
    start = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    repeat (5) @(negedge clk);
    check_output("idle_after_reset", 64'({rd_req, busy}), 64'(0));

    // Full pattern frame, rd_valid one clk after rd_req
    $display("[TB] full pattern frame");
    clear_frame_state();
    apply_stimulus();
    wait_done(12000, 0);
    check_frame(1);

    // Stall before word 7 plus a stray start mid-frame
    $display("[TB] stall frame");
    clear_frame_state();
    stall_word = 7;
    apply_stimulus();
    repeat (100) @(posedge clk);
    apply_stimulus();
    wait_done(12000, 0);
    stall_word = -1;
    check_frame(1);
    repeat (20) @(negedge clk);
    check_output("no_second_frame", 64'({busy, rd_req}), 64'(0));

    // Start without the grant
    $display("[TB] gating");
    clear_frame_state();
    en = 1'b0;
    apply_stimulus();
    repeat (50) @(negedge clk);
    check_output("gated_busy", 64'({busy, rd_req}), 64'(0));
    check_output("gated_sclk", 64'(sclk_rises), 64'(0));
    en = 1'b1;

    // Randomized frames: random data, latency, en toggling, stray starts, noise
    pattern_mode = 0; rand_delay = 1; noise_en = 1;
    for (int f = 0; f < 2; f++) begin
      $display("[TB] random frame %0d", f);
      clear_frame_state();
      apply_stimulus();
      wait_done(14000, 1);
      check_frame(0);
      repeat (2) @(negedge clk);
    end
    pattern_mode = 1; rand_delay = 0; noise_en = 0;

    // Reset in the middle of word 4
    $display("[TB] mid-frame reset");
    clear_frame_state();
    apply_stimulus();
    found = 0;
    for (int n = 0; n < 6000 && !found; n++) begin
      @(posedge clk); #2;
      if (m_busy && !m_fetch && m_word == 4 && m_k == 7) found = 1;
    end
    check_output("reached_word4", 64'(found), 64'(1));
    rst = 1'b0;
    #1;
    check_output("reset_mid_outputs", 64'({SCLK, SOUT, LAT, rd_req, busy, done}), 64'(0));
    rises_before = sclk_rises;
    repeat (3) @(negedge clk);
    check_output("reset_mid_no_sclk", 64'(sclk_rises), 64'(rises_before));
    @(posedge clk); #2 rst = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] clean frame after reset");
    clear_frame_state();
    apply_stimulus();
    wait_done(12000, 0);
    check_frame(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
